// File: rtl/hazard_forward_if.sv
// Decode/EX/cache control bundle between the core pipeline and the hazard unit.
// The pipeline side is master; the hazard unit is slave.
interface hazard_forward_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_branch_taken;
    logic             dcache_stall;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall_fd;
    logic             flush_fd;
    logic             bubble_ex;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2,
        output id_uses_rs1, id_uses_rs2,
        output id_rd, id_reg_write, id_mem_read,
        output ex_branch_taken, dcache_stall,
        input  fwd_a_sel, fwd_b_sel,
        input  stall_fd, flush_fd, bubble_ex,
        input  stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2,
        input  id_uses_rs1, id_uses_rs2,
        input  id_rd, id_reg_write, id_mem_read,
        input  ex_branch_taken, dcache_stall,
        output fwd_a_sel, fwd_b_sel,
        output stall_fd, flush_fd, bubble_ex,
        output stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard controller: shadow register tags, operand forwarding selects,
// load-use stall, branch flush and a saturating stall-cycle counter.
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_forward_if.slave     hif
);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             mr;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             u1;
        logic             u2;
    } ex_tag_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             mr;
    } mem_tag_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             we;
    } wb_tag_t;

    ex_tag_t          ex_q;
    mem_tag_t         mem_q;
    wb_tag_t          wb_q;
    logic [CNT_W-1:0] cnt_q;

    logic lu;
    logic stall_fd;
    logic flush_fd;
    logic bubble_ex;
    logic hit1;
    logic hit2;

    function automatic logic [1:0] fsel(
        input logic [REG_W-1:0] rs,
        input logic             u,
        input mem_tag_t         m,
        input wb_tag_t          w
    );
        logic [1:0] s;
        s = 2'b00;
        // Loads in MEM are skipped: their data only exists from WB on.
        if (u && m.v && m.we && !m.mr && m.rd != '0 && m.rd == rs)
            s = 2'b11;
        else if (u && w.v && w.we && w.rd != '0 && w.rd == rs)
            s = 2'b01;
        return s;
    endfunction

    assign hit1 = hif.id_uses_rs1 && (hif.id_rs1 == ex_q.rd);
    assign hit2 = hif.id_uses_rs2 && (hif.id_rs2 == ex_q.rd);

    assign lu = hif.id_valid && ex_q.v && ex_q.mr && ex_q.we
              && (ex_q.rd != '0) && (hit1 || hit2);

    always_comb begin
        stall_fd  = 1'b0;
        flush_fd  = 1'b0;
        bubble_ex = 1'b0;
        if (rst_n) begin
            priority case (1'b1)
                hif.dcache_stall: stall_fd = 1'b1;
                hif.ex_branch_taken: begin
                    flush_fd  = 1'b1;
                    bubble_ex = 1'b1;
                end
                lu: begin
                    stall_fd  = 1'b1;
                    bubble_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hif.dcache_stall) begin
            wb_q  <= '{v: mem_q.v, rd: mem_q.rd, we: mem_q.we};
            mem_q <= '{v: ex_q.v, rd: ex_q.rd,
                       we: ex_q.we, mr: ex_q.mr};
            if (bubble_ex)
                ex_q <= '0;
            else
                ex_q <= '{v:   hif.id_valid,
                          rd:  hif.id_rd,
                          we:  hif.id_reg_write,
                          mr:  hif.id_mem_read,
                          rs1: hif.id_rs1,
                          rs2: hif.id_rs2,
                          u1:  hif.id_uses_rs1,
                          u2:  hif.id_uses_rs2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if ((stall_fd || hif.dcache_stall) && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign hif.fwd_a_sel    = fsel(ex_q.rs1, ex_q.u1, mem_q, wb_q);
    assign hif.fwd_b_sel    = fsel(ex_q.rs2, ex_q.u2, mem_q, wb_q);
    assign hif.stall_fd     = stall_fd;
    assign hif.flush_fd     = flush_fd;
    assign hif.bubble_ex    = bubble_ex;
    assign hif.stall_cycles = cnt_q;

endmodule
